jk_excitation_driver: RTL
=========================

Name: jk_excitation_driver

Overview:
- Drives a bank of WIDTH JK flip-flops to a requested target state.
- Accepts a target word over a valid/ready handshake and derives per-bit J/K from the JK excitation table, using the bank's current Q fed back on q_in.
- Applies the J/K for exactly one clock edge, then checks the bank's Q against the target.
- On mismatch it retries up to MAX_RETRY times, then reports done or err. This is the write-side counterpart of the JK flip-flop bank.

Parameters:
- WIDTH, 4, number of JK flip-flops driven (1..32).
- MAX_RETRY, 2, extra DRIVE attempts after the first failed check (0..7).
- TOGGLE_MODE, 0. Fill rule for excitation don't-cares. 0: a change uses a set or reset code (J/K = 10 or 01). 1: a change uses the toggle code (J/K = 11).

Ports:
- clk  input  1  rising-edge clock, shared with the JK bank.
- rst  input  1  asynchronous reset, active-high.
- tgt_data  input  WIDTH  requested Q value.
- tgt_valid  input  1  tgt_data valid.
- tgt_ready  output  1  block can accept a target.
- q_in  input  WIDTH  Q outputs of the JK bank.
- j_out  output  WIDTH  J inputs to the bank (registered).
- k_out  output  WIDTH  K inputs to the bank (registered).
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse: bank matches target.
- err  output  1  one-cycle pulse: retries exhausted.
- mismatch  output  WIDTH  q_in XOR target at final failed check; held until next accept.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; j_out=0, k_out=0, done=0, err=0, busy=0, mismatch=0; retry count=0; tgt_ready=1 once rst deasserts. Reset mid-transaction abandons it immediately, with no done/err pulse.
- States: IDLE, DRIVE, CHECK.
- IDLE: tgt_ready=1, busy=0, j_out=k_out=0 (bank holds).
  - Accept on an edge with tgt_valid && tgt_ready.
  - On accept: register target; compute J/K per bit from q_in sampled at that edge; clear mismatch; retry count=0; go to DRIVE.
- Excitation per bit, as (Q, target) -> J K:
  - TOGGLE_MODE=0: 0,0 -> 00; 0,1 -> 10; 1,0 -> 01; 1,1 -> 00.
  - TOGGLE_MODE=1: 0,0 -> 00; 0,1 -> 11; 1,0 -> 11; 1,1 -> 00.
  - Code 11 is never driven on a bit that should hold.
- DRIVE (exactly 1 cycle): j_out/k_out carry the computed codes; busy=1; tgt_ready=0. The bank captures them at the end-of-cycle edge. On that edge, j_out=k_out=0 and state goes to CHECK.
- CHECK (1 cycle): j_out=k_out=0; busy=1. At the end-of-cycle edge, compare q_in with the registered target.
  - Equal: done=1 for the next cycle; go to IDLE.
  - Unequal and retry count < MAX_RETRY: increment count; recompute J/K from current q_in; go to DRIVE.
  - Unequal and count == MAX_RETRY: err=1 for the next cycle; mismatch = q_in ^ target; go to IDLE.
- Latency, fault-free: accept at edge N → DRIVE during N..N+1 → CHECK during N+1..N+2 → done high during N+2..N+3 with tgt_ready=1.
  - Each retry adds 2 cycles.
  - A new accept may occur on edge N+3, i.e. the same cycle done is high.
- A target equal to the current Q still passes through DRIVE with all codes 00, then CHECK, then done. This gives fixed 2-cycle latency.
- tgt_data and tgt_valid are ignored while busy. There is no backpressure on done/err.
- done and err are never high in the same cycle.
- For any bit, j_out and k_out are never both 1 when TOGGLE_MODE=0.

Test Plan:
- Reset mid-DRIVE: assert rst asynchronously → j_out/k_out/busy/done/err go 0 immediately, with no clock edge; tgt_ready=1 after release.
- Basic set/reset, WIDTH=4, TOGGLE_MODE=0, bank Q=0000, target 1010 → DRIVE j_out=1010, k_out=0000; done 2 cycles after accept; bank Q=1010. Then target 0110 → j_out=0100, k_out=1000; done; bank Q=0110.
- Toggle mode, TOGGLE_MODE=1, Q=1100, target 0101 → j_out=k_out=1001 for one cycle; Q=0101; done.
- Retry success: bench forces bit0 of q_in stuck at 0 for the first CHECK only; target 0001 → second DRIVE j_out=0001; done at accept+4; err never high.
- Retry exhaustion: MAX_RETRY=2, bit2 stuck at 0, target 0100 → 3 DRIVE cycles; err pulse at accept+6; mismatch=0100; done never high.
- Back-to-back: hold tgt_valid=1 with targets 1111 then 0000 → second accept on the done cycle; j_out=0000, k_out=1111; tgt_ready low during DRIVE and CHECK; two done pulses 3 cycles apart.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver
//   Drives a bank of WIDTH JK flip-flops to a requested target state. A target
//   word is accepted over a valid/ready handshake. Per-bit J/K codes are derived
//   from the JK excitation table, using the bank Q fed back on q_in. The codes
//   are applied for exactly one clock edge, and then the bank Q is checked
//   against the target. On a mismatch the driver retries up to MAX_RETRY times
//   before it reports err.
//
// Parameters
//   WIDTH       number of JK flip-flops driven (1..32)
//   MAX_RETRY   extra DRIVE attempts after the first failed check (0..7)
//   TOGGLE_MODE 0: a change uses the set/reset codes (10/01); 1: a change uses the toggle code (11)
//
// Ports
//   clk       rising-edge clock, shared with the JK bank
//   rst       asynchronous reset, active-high
//   tgt_data  requested Q value
//   tgt_valid tgt_data valid
//   tgt_ready block can accept a target
//   q_in      Q outputs of the JK bank
//   j_out     J inputs to the bank (registered)
//   k_out     K inputs to the bank (registered)
//   busy      transaction in progress
//   done      one-cycle pulse: bank matches target
//   err       one-cycle pulse: retries exhausted
//   mismatch  q_in ^ target at the final failed check, held until the next accept
module jk_excitation_driver #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned TOGGLE_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] mismatch
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_RETRY);

  state_t           state, state_n;
  logic [WIDTH-1:0] tgt_reg, tgt_n;
  logic [WIDTH-1:0] j_n, k_n, mis_n;
  logic             done_n, err_n;
  logic [2:0]       cnt, cnt_n;

  // Returns {J, K}. A bit that already matches its target always gets 00, so
  // the 11 code can only appear on a changing bit, and only in toggle mode.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] j, k;
    if (TOGGLE_MODE != 0) begin
      j = q ^ t;
      k = q ^ t;
    end else begin
      j = ~q & t;
      k = q & ~t;
    end
    return {j, k};
  endfunction

  // While rst is asserted, tgt_ready is held low so that it rises only once
  // rst is released.
  assign tgt_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    tgt_n   = tgt_reg;
    j_n     = '0;
    k_n     = '0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    mis_n   = mismatch;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          state_n    = DRIVE;
          tgt_n      = tgt_data;
          {j_n, k_n} = excite(q_in, tgt_data);
          mis_n      = '0;
          cnt_n      = '0;
        end
      end
      DRIVE: begin
        state_n = CHECK;
      end
      CHECK: begin
        if (q_in == tgt_reg) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt < MAX_CNT) begin
          cnt_n      = cnt + 3'd1;
          {j_n, k_n} = excite(q_in, tgt_reg);
          state_n    = DRIVE;
        end else begin
          err_n   = 1'b1;
          mis_n   = q_in ^ tgt_reg;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tgt_reg  <= '0;
      j_out    <= '0;
      k_out    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      mismatch <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      tgt_reg  <= tgt_n;
      j_out    <= j_n;
      k_out    <= k_n;
      done     <= done_n;
      err      <= err_n;
      mismatch <= mis_n;
      cnt      <= cnt_n;
    end
  end

endmodule
